// File: rtl/a5_keystream_sequencer_if.sv
// Keystream word stream (valid/ready) between the A5/1 sequencer and its consumer.
// Optional macro A5_SEQ_DUAL_BURST_EN adds out_dir (0 = downlink, 1 = uplink).
interface a5_keystream_sequencer_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] out_data;
  logic [3:0]        out_nbits;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
`ifdef A5_SEQ_DUAL_BURST_EN
  logic              out_dir;
`endif

  modport master (
    output out_data, out_nbits, out_last, out_valid,
`ifdef A5_SEQ_DUAL_BURST_EN
    output out_dir,
`endif
    input  out_ready
  );

  modport slave (
    input  out_data, out_nbits, out_last, out_valid,
`ifdef A5_SEQ_DUAL_BURST_EN
    input  out_dir,
`endif
    output out_ready
  );
endinterface

// File: rtl/a5_keystream_sequencer.sv
// A5/1 keystream sequencer: load, inject key/frame, mix, then pack keystream bits into words.
// Optional macro A5_SEQ_DUAL_BURST_EN splits the keystream into two bursts tagged by out_dir.
module a5_keystream_sequencer #(
  parameter int INJECT_CYCLES  = 86,
  parameter int MIX_CYCLES     = 101,
  parameter int KEYSTREAM_BITS = 228,
  parameter int WORD_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic        busy,
  output logic        done,
  output logic        gen_load,
  output logic        gen_clk_en,
  output logic [63:0] gen_key,
  output logic [21:0] gen_frame,
  input  logic        gen_d,
  a5_keystream_sequencer_if.master out_if
);

  localparam int PHASE_MAX = (INJECT_CYCLES > MIX_CYCLES) ? INJECT_CYCLES : MIX_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX);
  localparam int CNT_W     = $clog2(KEYSTREAM_BITS + 1);
  localparam int IDX_W     = $clog2(WORD_W);
`ifdef A5_SEQ_DUAL_BURST_EN
  localparam int BURST_BITS = KEYSTREAM_BITS / 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INJECT, S_MIX, S_RUN, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [PHASE_W-1:0]  r_phase;
  logic [63:0]         r_key;
  logic [21:0]         r_frame;
  logic [WORD_W-1:0]   r_collect;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]   r_out_data;
  logic [3:0]          r_out_nbits;
  logic                r_out_last;
  logic                r_out_valid;

  logic w_start_ok;
  logic w_abort;
  logic w_capture;
  logic w_burst_end;
  logic w_word_end;
  logic w_handshake;
  logic w_final;

  assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
  assign w_abort     = abort && (r_state != S_IDLE);
  // The generator only steps while no word is waiting, so a stalled consumer loses no bits.
  assign w_capture   = (r_state == S_RUN) && !r_out_valid &&
                       (r_bit_cnt < CNT_W'(KEYSTREAM_BITS));
`ifdef A5_SEQ_DUAL_BURST_EN
  assign w_burst_end = (r_bit_cnt == CNT_W'(BURST_BITS - 1)) ||
                       (r_bit_cnt == CNT_W'(KEYSTREAM_BITS - 1));
`else
  assign w_burst_end = (r_bit_cnt == CNT_W'(KEYSTREAM_BITS - 1));
`endif
  assign w_word_end  = w_capture && ((r_bit_idx == IDX_W'(WORD_W - 1)) || w_burst_end);
  assign w_handshake = r_out_valid && out_if.out_ready;
  assign w_final     = w_handshake && r_out_last && (r_bit_cnt == CNT_W'(KEYSTREAM_BITS));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start_ok) w_next_state = S_LOAD;
        S_LOAD:   w_next_state = S_INJECT;
        S_INJECT: if (r_phase == PHASE_W'(INJECT_CYCLES - 1)) w_next_state = S_MIX;
        S_MIX:    if (r_phase == PHASE_W'(MIX_CYCLES - 1)) w_next_state = S_RUN;
        S_RUN:    if (w_final) w_next_state = S_DONE;
        S_DONE:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    gen_load   = 1'b0;
    gen_clk_en = 1'b0;
    case (r_state)
      S_LOAD:   begin busy = 1'b1; gen_load = 1'b1; end
      S_INJECT: begin busy = 1'b1; gen_clk_en = 1'b1; end
      S_MIX:    begin busy = 1'b1; gen_clk_en = 1'b1; end
      S_RUN:    begin busy = 1'b1; gen_clk_en = w_capture; end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Phase counter restarts on every state change and paces INJECT and MIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_phase <= '0;
    else if (r_state != w_next_state)  r_phase <= '0;
    else if (r_state == S_INJECT || r_state == S_MIX)
                                       r_phase <= r_phase + 1'b1;
  end

  // NOTE: every register here is plain flop state with a defined reset value; there is no memory array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key   <= '0;
      r_frame <= '0;
    end else if (w_start_ok) begin
      r_key   <= key;
      r_frame <= frame;
    end
  end

`ifdef A5_SEQ_DUAL_BURST_EN
  logic r_out_dir;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_collect   <= '0;
      r_bit_idx   <= '0;
      r_bit_cnt   <= '0;
      r_out_data  <= '0;
      r_out_nbits <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef A5_SEQ_DUAL_BURST_EN
      r_out_dir   <= 1'b0;
`endif
    end else if (w_abort || r_state != S_RUN) begin
      r_collect   <= '0;
      r_bit_idx   <= '0;
      r_bit_cnt   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_capture) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_word_end) begin
          r_out_data  <= r_collect | (WORD_W'(gen_d) << r_bit_idx);
          r_out_nbits <= 4'(r_bit_idx) + 4'd1;
          r_out_last  <= w_burst_end;
          r_out_valid <= 1'b1;
`ifdef A5_SEQ_DUAL_BURST_EN
          r_out_dir   <= (r_bit_cnt >= CNT_W'(BURST_BITS));
`endif
          r_collect   <= '0;
          r_bit_idx   <= '0;
        end else begin
          r_collect[r_bit_idx] <= gen_d;
          r_bit_idx            <= r_bit_idx + 1'b1;
        end
      end
    end
  end

  assign gen_key          = r_key;
  assign gen_frame        = r_frame;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_nbits = r_out_nbits;
  assign out_if.out_last  = r_out_last;
  assign out_if.out_valid = r_out_valid;
`ifdef A5_SEQ_DUAL_BURST_EN
  assign out_if.out_dir   = r_out_dir;
`endif

endmodule

// File: tb/tb_a5_keystream_sequencer.sv
// Self-checking bench for a5_keystream_sequencer with a step-counting stand-in generator.
// Honours A5_SEQ_DUAL_BURST_EN when defined for both bench and design.
module tb_a5_keystream_sequencer;

  localparam int WORD_W    = 8;
  localparam int KS_BITS   = 228;
  localparam int PRE_STEPS = 187;
`ifdef A5_SEQ_DUAL_BURST_EN
  localparam int BURST = 114;
  localparam int NW    = 30;
`else
  localparam int BURST = 228;
  localparam int NW    = 29;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy, done, gen_load, gen_clk_en;
  logic [63:0] gen_key;
  logic [21:0] gen_frame;
  logic        gen_d;
  logic        w_dir;

  a5_keystream_sequencer_if #(.WORD_W(WORD_W)) out_if ();

  a5_keystream_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key(key), .frame(frame), .busy(busy), .done(done),
    .gen_load(gen_load), .gen_clk_en(gen_clk_en),
    .gen_key(gen_key), .gen_frame(gen_frame), .gen_d(gen_d),
    .out_if(out_if)
  );

`ifdef A5_SEQ_DUAL_BURST_EN
  assign w_dir = out_if.out_dir;
`else
  assign w_dir = 1'b0;
`endif

  always #5 clk = ~clk;

  // Stand-in generator: output is a key/frame-dependent function of the number of steps since load.
  logic [63:0] m_key   = '0;
  logic [21:0] m_frame = '0;
  int          m_steps = 0;

  function automatic logic ks_fn(input logic [63:0] k, input logic [21:0] f, input int n);
    return k[n % 64] ^ f[n % 22] ^ n[0] ^ n[4];
  endfunction

  always @(posedge clk) begin
    if (gen_load) begin
      m_key   <= gen_key;
      m_frame <= gen_frame;
      m_steps <= 0;
    end else if (gen_clk_en) begin
      m_steps <= m_steps + 1;
    end
  end

  assign gen_d = ks_fn(m_key, m_frame, m_steps);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_data [40];
  int         exp_nbits[40];
  bit         exp_last [40];
  bit         exp_dir  [40];
  int         exp_nw;

  task automatic build_expected(input logic [63:0] k, input logic [21:0] f);
    logic [7:0] acc;
    int idx;
    acc = '0;
    idx = 0;
    exp_nw = 0;
    for (int i = 0; i < KS_BITS; i++) begin
      acc[idx] = ks_fn(k, f, PRE_STEPS + i);
      idx++;
      if (idx == WORD_W || (i % BURST) == BURST - 1) begin
        exp_data[exp_nw]  = acc;
        exp_nbits[exp_nw] = idx;
        exp_last[exp_nw]  = ((i % BURST) == BURST - 1);
        exp_dir[exp_nw]   = (i >= BURST);
        exp_nw++;
        acc = '0;
        idx = 0;
      end
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic [21:0] frame;
    int          ready_mode;    // 0: always ready, 1: random plus a 50-cycle stall
    int          abort_cyc;
    int          abort_word;
    int          dup_start_cyc;
    int          reset_cyc;
    bit          start_at_done;
    int          exp_words;
    int          exp_done;
  } vec_t;

  task automatic run_session(input vec_t v);
    int cyc, nwords, nload, first_load, first_en, en_pre, en_total, first_valid, ndone;
    int viol_en, viol_stall, end_cyc, hold, done_chk;
    bit prev_stall, abort_prev, abort_req, rdy;
    logic [13:0] prev_word, cur_word;
    nwords = 0; nload = 0; first_load = -1; first_en = -1; en_pre = 0; en_total = 0;
    first_valid = -1; ndone = 0; viol_en = 0; viol_stall = 0; end_cyc = -1; hold = 0;
    done_chk = -1; prev_stall = 0; abort_prev = 0; abort_req = 0; prev_word = '0;
    build_expected(v.key, v.frame);
    @(negedge clk);
    key = v.key; frame = v.frame; start = 1'b1; out_if.out_ready = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0; key = v.key; frame = v.frame;
      if (abort_prev) begin
        abort = 1'b0;
        abort_prev = 0;
        check("abort_to_idle", {busy, out_if.out_valid, gen_clk_en, gen_load}, 0);
        end_cyc = cyc + 20;
      end
      cur_word = {w_dir, out_if.out_last, out_if.out_nbits, out_if.out_data};
      if (gen_load) begin
        nload++;
        if (first_load < 0) first_load = cyc;
      end
      if (gen_clk_en) begin
        en_total++;
        if (first_en < 0) first_en = cyc;
        if (cyc <= 188) en_pre++;
      end
      if (out_if.out_valid && first_valid < 0) first_valid = cyc;
      if (gen_clk_en && out_if.out_valid) viol_en++;
      if (prev_stall && (!out_if.out_valid || cur_word != prev_word)) viol_stall++;
      if (cyc == done_chk) check("start_in_done_ignored", {busy, gen_load}, 0);
      if (done) begin
        ndone++;
        check("busy_low_on_done", busy, 0);
        if (end_cyc < 0) end_cyc = cyc + 2;
        if (v.start_at_done) begin
          start = 1'b1; key = ~v.key; done_chk = cyc + 1;
        end
      end
      if (cyc == v.abort_cyc || abort_req) begin
        abort = 1'b1; abort_prev = 1; abort_req = 0;
      end
      if (v.ready_mode == 0) rdy = 1'b1;
      else if (hold > 0) begin rdy = 1'b0; hold--; end
      else rdy = 1'($urandom_range(0, 1));
      out_if.out_ready = rdy;
      if (out_if.out_valid && rdy) begin
        if (nwords < exp_nw)
          check($sformatf("word%0d", nwords), cur_word,
                {exp_dir[nwords], exp_last[nwords], 4'(exp_nbits[nwords]), exp_data[nwords]});
        nwords++;
        if (v.ready_mode == 1 && nwords == 10) hold = 50;
        if (nwords == v.abort_word) abort_req = 1;
      end
      prev_stall = out_if.out_valid && !rdy;
      prev_word  = cur_word;
      if (cyc == v.dup_start_cyc) begin
        start = 1'b1; key = ~v.key; frame = ~v.frame;
      end
      if (cyc == v.reset_cyc) begin
        reset = 1'b1;
        #1;
        check("async_reset_drop",
              {busy, done, gen_load, gen_clk_en, out_if.out_valid, out_if.out_last}, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        break;
      end
      if (cyc == end_cyc) break;
      if (cyc >= 3000) begin
        check("session_timeout", 1, 0);
        break;
      end
    end
    abort = 1'b0; start = 1'b0; out_if.out_ready = 1'b1;
    check("word_count", nwords, v.exp_words);
    check("done_count", ndone, v.exp_done);
    check("load_count", nload, 1);
    check("load_cycle", first_load, 1);
    check("clk_en_first_cycle", first_en, 2);
    check("clk_en_while_valid", viol_en, 0);
    check("stall_stability", viol_stall, 0);
    if (v.exp_done != 0) begin
      check("clk_en_pre_run", en_pre, 187);
      check("clk_en_total", en_total, PRE_STEPS + KS_BITS);
      check("first_valid_cycle", first_valid, 197);
      check("latched_key_frame", {gen_key, gen_frame}, {v.key, v.frame});
    end
  endtask

  localparam logic [63:0] KEY_KA = 64'h1223_4567_89AB_CDEF;
  localparam logic [63:0] KEY_A  = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] KEY_B  = 64'hFFFF_0000_A5A5_5A5A;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{64'h0, 22'h0,      0,  -1, -1,  -1,  -1, 1'b1, NW, 1};
    vecs[1] = '{KEY_KA, 22'h134,   0,  -1, -1,  -1,  -1, 1'b0, NW, 1};
    vecs[2] = '{KEY_KA, 22'h134,   1,  -1, -1,  -1,  -1, 1'b0, NW, 1};
    vecs[3] = '{KEY_A,  22'h2A5A5, 0, 120, -1,  -1,  -1, 1'b0, 0,  0};
    vecs[4] = '{KEY_A,  22'h2A5A5, 0,  -1,  5,  -1,  -1, 1'b0, 5,  0};
    vecs[5] = '{KEY_A,  22'h2A5A5, 0,  -1, -1,  -1,  -1, 1'b0, NW, 1};
    vecs[6] = '{KEY_B,  22'h3FFFF, 1,  -1, -1, 200,  -1, 1'b0, NW, 1};
    vecs[7] = '{KEY_B,  22'h3FFFF, 0,  -1, -1,  -1, 150, 1'b0, 0,  0};
    vecs[8] = '{KEY_A,  22'h0155A, 1,  -1, -1,  -1,  -1, 1'b0, NW, 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; key = '0; frame = '0;
    out_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, gen_load, gen_clk_en, out_if.out_valid, out_if.out_last}, 0);
    check("reset_data", {out_if.out_data, out_if.out_nbits}, 0);
    check("reset_latch", {gen_key, gen_frame}, 0);
    reset = 1'b0;
    @(negedge clk);

    key = KEY_B; frame = 22'h1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", {busy, gen_load}, 0);
    check("abort_start_no_latch", {gen_key, gen_frame}, 0);
    repeat (2) @(negedge clk);
    check("still_idle", busy, 0);

    for (int i = 0; i < 9; i++) begin
      run_session(vecs[i]);
      repeat (3) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/a5_keystream_sequencer.md
Name: a5_keystream_sequencer

Overview:
- Control sequencer for the A5/1 keystream generator.
- Per session: latches a 64-bit key and 22-bit frame number, then drives the generator through load, key/frame injection and mixing.
- Collects the 228 keystream bits into 8-bit words and presents them on a valid/ready stream.
- Sits between the host/bus interface and the generator instance; it is the only driver of the generator's load, clock-enable, key and frame inputs.

Parameters:
- INJECT_CYCLES, 86, generator steps with injection active after load (64 key + 22 frame bits).
- MIX_CYCLES, 101, steps between end of injection and first captured bit (100 discard steps + first output step).
- KEYSTREAM_BITS, 228, total keystream bits delivered per session.
- WORD_W, 8, output word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  begin session; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- key  in  64  session key; latched on accepted start.
- frame  in  22  frame number; latched on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final word handshake.
- gen_load  out  1  generator load strobe.
- gen_clk_en  out  1  generator step enable.
- gen_key  out  64  latched key to generator.
- gen_frame  out  22  latched frame to generator.
- gen_d  in  1  generator keystream bit (combinational from generator state).
- out_data  out  WORD_W  keystream word, bit 0 = earliest bit.
- out_nbits  out  4  number of valid bits in out_data (1..WORD_W).
- out_last  out  1  marks the final word of a burst.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts word when high with out_valid.

Behaviour:
- Reset values:
  - Outputs: busy, done, gen_load, gen_clk_en, out_valid and out_last are 0; out_data is 0; out_nbits is 0.
  - Internal state: key/frame latches are 0; FSM is IDLE.
  - Reset asserted mid-session aborts immediately; no partial word is emitted after release.
- FSM states: IDLE, LOAD, INJECT, MIX, RUN, DONE.
- IDLE:
  - start=1 latches key/frame and goes to LOAD.
  - Cycle of accepted start = cycle 0.
- LOAD (cycle 1):
  - gen_load=1 and gen_clk_en=0 for exactly one cycle.
  - Always followed directly by INJECT. The generator's injection shift register advances every cycle after load, so no gap is allowed.
- INJECT (cycles 2..87):
  - gen_clk_en=1 for exactly INJECT_CYCLES consecutive cycles.
  - Then MIX.
- MIX (cycles 88..188):
  - gen_clk_en=1 for MIX_CYCLES cycles.
  - gen_d is ignored.
  - Then RUN.
- RUN:
  - Each cycle with out_valid=0 and bits remaining: gen_clk_en=1, and gen_d is captured into bit position bit_idx of the collect register.
  - The captured value is the pre-step value: the first captured bit reflects the state after MIX_CYCLES steps.
  - When bit_idx reaches WORD_W, or the last bit of a burst is captured, the register moves to out_data next cycle with out_valid=1 and out_nbits set.
  - While out_valid=1, gen_clk_en=0; the generator is stalled and no bits are lost.
  - out_data, out_nbits and out_last are held stable while out_valid && !out_ready.
  - Capture resumes the cycle after the handshake.
- Word count: 228 bits = 28 words of 8 bits + 1 final word of 4 bits, with out_nbits=4 and out_last=1. Unused out_data bits are 0.
- First out_valid: cycle 197 with out_ready held high (captures in cycles 189..196).
- DONE:
  - Entered after the out_last handshake.
  - done=1 for one cycle, busy=0 that cycle, then IDLE.
  - start in the DONE cycle is ignored.
- start while busy is ignored; the latched key/frame are unchanged.
- abort:
  - In any non-IDLE state: next cycle is IDLE; out_valid, gen_clk_en and gen_load are 0; no done pulse.
  - abort and start together in IDLE: abort wins, start is ignored.
- Counters are sized for their parameter maximums. The bit counter saturates at KEYSTREAM_BITS, and no gen_clk_en is issued after the final capture.

Optional Feature:
- Macro: A5_SEQ_DUAL_BURST_EN.
- With the macro defined:
  - Keystream is split into two 114-bit bursts (downlink, then uplink).
  - Extra output port out_dir (1 bit): 0 for bits 0..113, 1 for bits 114..227.
  - Words never straddle bursts: each burst is 14 full words + 1 word with out_nbits=2 and out_last=1.
  - done follows only the second burst's out_last.
- Without the macro: no out_dir port; a single 228-bit burst; out_last only on word 29.

Test Plan:
- Reset, start with key=64'h0 and frame=0, out_ready=1:
  - gen_load high at cycle 1 only.
  - gen_clk_en high for cycles 2..188 contiguous.
  - First out_valid at cycle 197.
  - 29 words; last word has out_nbits=4 and out_last=1.
  - done pulses once.
- Known-answer: key=64'h12_23_45_67_89_AB_CD_EF, frame=22'h134 with the generator attached:
  - 228 bits match the GSM A5/1 reference keystream.
  - Words are packed LSB-first.
- Backpressure: out_ready toggled randomly and held low 50 cycles mid-run:
  - gen_clk_en=0 whenever out_valid=1.
  - out_data stable while stalled.
  - Collected bits are identical to the out_ready=1 run.
- abort asserted in MIX (cycle 120), then in RUN after word 5:
  - IDLE next cycle; busy=0; no done.
  - A fresh start yields the full correct stream.
- start pulsed while busy with a different key:
  - Ignored; output stream is unchanged.
  - Asynchronous reset at cycle 150 drops all outputs immediately.
- With A5_SEQ_DUAL_BURST_EN: 30 words total.
  - out_last on word 15 (out_nbits=2, out_dir=0) and word 30 (out_nbits=2, out_dir=1).
  - A single done pulse.
